// File: rtl/stepper_sequencer.sv
// rtl/stepper_sequencer.sv - command-paced 4-bit Johnson phase sequencer
// Accepts step/direction/period commands in IDLE and walks the Johnson ring one state per step.
module stepper_sequencer #(
  parameter int CNT_W = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] steps,
  input  logic [DIV_W-1:0] period,
  input  logic             abort,
  output logic [3:0]       phase,
  output logic             step_strobe,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [3:0]       phase_q, phase_d;
  logic             strobe_q, strobe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic             dir_q, dir_d;

  logic       step_due;
  logic [3:0] phase_step;

  assign step_due   = (div_q == '0);
  assign phase_step = dir_q ? {~phase_q[0], phase_q[3:1]} : {phase_q[2:0], ~phase_q[3]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (steps != '0) ? S_RUN : S_FINISH;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_FINISH;
        end else if (step_due && (remaining_q == CNT_W'(1))) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    phase_d     = phase_q;
    strobe_d    = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    remaining_d = remaining_q;
    div_d       = div_q;
    period_d    = period_q;
    dir_d       = dir_q;
    case (state_q)
      S_IDLE: begin
        if (start && (steps != '0)) begin
          dir_d       = dir;
          period_d    = period;
          div_d       = period;
          remaining_d = steps;
          busy_d      = 1'b1;
        end
      end
      S_RUN: begin
        // Abort reports completion immediately; FINISH then skips its own pulse.
        if (abort) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else if (!step_due) begin
          div_d = div_q - DIV_W'(1);
        end else begin
          phase_d     = phase_step;
          strobe_d    = 1'b1;
          remaining_d = remaining_q - CNT_W'(1);
          div_d       = period_q;
        end
      end
      S_FINISH: begin
        busy_d = 1'b0;
        done_d = ~done_q;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q     <= 4'b0000;
      strobe_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      remaining_q <= '0;
      div_q       <= '0;
      period_q    <= '0;
      dir_q       <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      strobe_q    <= strobe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      remaining_q <= remaining_d;
      div_q       <= div_d;
      period_q    <= period_d;
      dir_q       <= dir_d;
    end
  end

  assign phase       = phase_q;
  assign step_strobe = strobe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign remaining   = remaining_q;

endmodule

// File: tb/tb_stepper_sequencer.sv
// tb/tb_stepper_sequencer.sv - self-checking bench for stepper_sequencer
// Expected outputs come from a timeline model: steps taken by edge e are derived arithmetically from the accept edge.
module tb_stepper_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       dir = 1'b0;
  logic [7:0] steps = 8'd0;
  logic [7:0] period = 8'd0;
  logic       abort = 1'b0;
  logic [3:0] phase;
  logic       step_strobe;
  logic       busy;
  logic       done;
  logic [7:0] remaining;

  stepper_sequencer #(.CNT_W(8), .DIV_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .steps(steps),
    .period(period), .abort(abort), .phase(phase), .step_strobe(step_strobe),
    .busy(busy), .done(done), .remaining(remaining)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int e = 0;
  int cnt_strobe, cnt_busy, cnt_done;

  logic [3:0] jtab [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                           4'b1111, 4'b1110, 4'b1100, 4'b1000};

  // Latest command: accept edge, count, period, direction, ring index and remaining before it.
  int c_valid, c_zero, c_acc, c_n, c_p, c_d, c_base, c_brem, c_abort;

  function automatic int m_last();
    return c_acc + c_n * (c_p + 1);
  endfunction

  function automatic int m_k(int t);
    int lim, kk;
    if (!c_valid || c_zero) return 0;
    lim = (c_abort >= 0) ? c_abort - 1 : t;
    if (lim > t) lim = t;
    if (lim < c_acc) return 0;
    kk = (lim - c_acc) / (c_p + 1);
    return (kk > c_n) ? c_n : kk;
  endfunction

  function automatic int m_pidx(int t);
    int k;
    if (!c_valid) return c_base;
    k = m_k(t);
    return ((c_base + (c_d ? -k : k)) % 8 + 8) % 8;
  endfunction

  function automatic int m_rem(int t);
    if (!c_valid || c_zero) return c_brem;
    return c_n - m_k(t);
  endfunction

  function automatic int m_done_edge();
    if (c_zero) return c_acc + 1;
    if (c_abort >= 0) return c_abort;
    return m_last() + 1;
  endfunction

  function automatic int m_free();
    if (!c_valid) return 0;
    return m_done_edge() + ((c_abort >= 0) ? 2 : 1);
  endfunction

  function automatic logic m_busy(int t);
    return c_valid && !c_zero && t >= c_acc && t < m_done_edge();
  endfunction

  function automatic logic m_done(int t);
    return c_valid && t == m_done_edge();
  endfunction

  function automatic logic m_strobe(int t);
    if (!c_valid || c_zero || t <= c_acc) return 1'b0;
    if ((t - c_acc) % (c_p + 1) != 0) return 1'b0;
    if ((t - c_acc) / (c_p + 1) > c_n) return 1'b0;
    if (c_abort >= 0 && t >= c_abort) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    c_valid = 0; c_zero = 0; c_base = 0; c_brem = 0; c_abort = -1;
    c_acc = 0; c_n = 0; c_p = 0; c_d = 0;
  endtask

  task automatic model_step();
    int nb, nr;
    if (abort && c_valid && !c_zero && c_abort < 0 && e >= c_acc + 1 && e <= m_last()) begin
      c_abort = e;
    end else if (start && e >= m_free()) begin
      nb = m_pidx(e - 1);
      nr = m_rem(e - 1);
      c_valid = 1; c_acc = e; c_n = int'(steps); c_p = int'(period); c_d = int'(dir);
      c_base = nb; c_brem = nr; c_zero = (steps == 8'd0); c_abort = -1;
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, e);
    end
  endtask

  task automatic compare_all();
    check("phase", 32'(phase), 32'(jtab[m_pidx(e)]));
    check("step_strobe", 32'(step_strobe), 32'(m_strobe(e)));
    check("busy", 32'(busy), 32'(m_busy(e)));
    check("done", 32'(done), 32'(m_done(e)));
    check("remaining", 32'(remaining), 32'(m_rem(e)));
    cnt_strobe += int'(step_strobe);
    cnt_busy   += int'(busy);
    cnt_done   += int'(done);
  endtask

  task automatic tick();
    @(posedge clk);
    e++;
    if (reset) model_reset();
    else model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_counts();
    cnt_strobe = 0; cnt_busy = 0; cnt_done = 0;
  endtask

  task automatic issue(logic d, int n, int p);
    dir = d; steps = 8'(n); period = 8'(p); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    model_reset();
    #1;
    compare_all();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    clear_counts();
    run(2);
    reset = 1'b0;
    check("reset_phase", 32'(phase), 32'h0);
    check("reset_remaining", 32'(remaining), 32'h0);

    clear_counts();
    issue(1'b0, 3, 0);
    run(5);
    check("fwd_phase", 32'(phase), 32'h7);
    check("fwd_strobes", 32'(cnt_strobe), 32'd3);
    check("fwd_busy_cycles", 32'(cnt_busy), 32'd4);
    check("fwd_done_pulses", 32'(cnt_done), 32'd1);

    clear_counts();
    issue(1'b1, 2, 3);
    run(10);
    check("rev_phase", 32'(phase), 32'h1);
    check("rev_strobes", 32'(cnt_strobe), 32'd2);
    check("rev_done_pulses", 32'(cnt_done), 32'd1);

    issue(1'b1, 1, 0);
    run(3);
    check("back_to_zero", 32'(phase), 32'h0);
    clear_counts();
    issue(1'b0, 9, 0);
    run(11);
    check("wrap_phase", 32'(phase), 32'h1);
    check("wrap_strobes", 32'(cnt_strobe), 32'd9);

    clear_counts();
    issue(1'b0, 10, 2);
    run(4);
    steps = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    run(6);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    run(2);
    check("abort_phase", 32'(phase), 32'hF);
    check("abort_remaining", 32'(remaining), 32'd7);
    check("abort_strobes", 32'(cnt_strobe), 32'd3);
    check("abort_done_pulses", 32'(cnt_done), 32'd1);

    clear_counts();
    issue(1'b0, 0, 0);
    run(2);
    check("zero_done_pulses", 32'(cnt_done), 32'd1);
    check("zero_busy_cycles", 32'(cnt_busy), 32'd0);
    check("zero_remaining", 32'(remaining), 32'd7);

    issue(1'b0, 5, 1);
    run(4);
    pulse_reset();
    check("midrun_reset_phase", 32'(phase), 32'h0);
    check("midrun_reset_busy", 32'(busy), 32'h0);
    clear_counts();
    run(12);
    check("no_done_after_reset", 32'(cnt_done), 32'd0);
    issue(1'b0, 1, 0);
    run(2);
    check("restart_phase", 32'(phase), 32'h1);

    for (int i = 0; i < 3000; i++) begin
      start  = ($urandom_range(0, 3) == 0);
      steps  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 6));
      period = 8'($urandom_range(0, 3));
      dir    = 1'($urandom_range(0, 1));
      abort  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) begin
        start = 1'b0;
        abort = 1'b0;
        pulse_reset();
      end else begin
        tick();
      end
    end
    start = 1'b0;
    abort = 1'b0;
    run(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
